// File: rtl/dispatcher_pkg.sv
// Shared encodings for the stream dispatcher: configuration modes and FSM states.
package dispatcher_pkg;

  typedef enum logic [1:0] {
    MODE_SEL   = 2'd0,
    MODE_RR    = 2'd1,
    MODE_AVAIL = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/dispatch_slot.sv
// One-entry output register with valid/ready take side and a saturating delivery counter.
module dispatch_slot #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              take,
  input  logic              cnt_clr,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              free,
  output logic [CNT_W-1:0]  cnt
);

  // A slot being emptied this cycle can be refilled on the same edge.
  assign free = !valid || take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (valid && take && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/demux_stream_dispatcher.sv
// Dispatches one valid/ready stream onto two registered channels by select, round-robin or availability.
module demux_stream_dispatcher
  import dispatcher_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              sel,
  input  logic [1:0]        cfg_mode,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic              busy
);

  state_e state;
  mode_e  active_mode;
  logic   rr_ptr;
  logic   free0, free1;
  logic   target, free_t, mode_chg, accept;

  always_comb begin
    target = sel;
    case (active_mode)
      MODE_RR:    target = rr_ptr;
      // Exactly one free slot wins; otherwise fall back to the pointer.
      MODE_AVAIL: target = (free0 ^ free1) ? free1 : rr_ptr;
      default:    target = sel;
    endcase
  end

  assign free_t   = target ? free1 : free0;
  assign mode_chg = (cfg_mode != active_mode);
  assign in_ready = (state == ST_RUN) && !mode_chg && free_t;
  assign accept   = in_valid && in_ready;

  dispatch_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept && !target),
    .load_data (in_data),
    .take      (out0_ready),
    .cnt_clr   (cnt_clr),
    .valid     (out0_valid),
    .data      (out0_data),
    .free      (free0),
    .cnt       (cnt0)
  );

  dispatch_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept && target),
    .load_data (in_data),
    .take      (out1_ready),
    .cnt_clr   (cnt_clr),
    .valid     (out1_valid),
    .data      (out1_data),
    .free      (free1),
    .cnt       (cnt1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      active_mode <= MODE_SEL;
      rr_ptr      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mode_chg) begin
            state <= ST_DRAIN;
            busy  <= 1'b1;
          end else if (accept && (active_mode == MODE_RR || active_mode == MODE_AVAIL)) begin
            rr_ptr <= ~target;
          end
        end
        default: begin
          // No loads happen here, so both slots free means both empty after this edge.
          if (free0 && free1) begin
            state       <= ST_RUN;
            busy        <= 1'b0;
            active_mode <= mode_e'(cfg_mode);
            rr_ptr      <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/demux_stream_dispatcher.md
Name: demux_stream_dispatcher

Overview:
Sequenced, handshaked version of the 1-to-2 demux datapath. It accepts a single valid/ready input stream and dispatches each word to one of two registered output channels. The destination comes from an external select, a round-robin pointer, or first-free-slot policy. It sits between a single producer and two consumers, and counts the words delivered per channel.

Parameters:
DATA_W, 8, width of data word
CNT_W, 16, width of per-channel delivered-word counters (saturating)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a word
in_ready  output  1  dispatcher accepts the word this cycle
in_data  input  DATA_W  producer word
sel  input  1  destination in MODE_SEL (0 -> out0, 1 -> out1), sampled at acceptance
cfg_mode  input  2  0 MODE_SEL, 1 MODE_RR, 2 MODE_AVAIL, 3 reserved (behaves as MODE_SEL)
out0_valid  output  1  channel 0 holds a word
out0_ready  input  1  consumer 0 takes the word
out0_data  output  DATA_W  channel 0 word
out1_valid  output  1  channel 1 holds a word
out1_ready  input  1  consumer 1 takes the word
out1_data  output  DATA_W  channel 1 word
cnt_clr  input  1  synchronous clear of both counters
cnt0  output  CNT_W  words delivered on channel 0
cnt1  output  CNT_W  words delivered on channel 1
busy  output  1  high in DRAIN state

Behaviour:
- Reset (async, rst_n=0): all outN_valid=0, outN_data=0, cnt0=cnt1=0, rr_ptr=0, active_mode=0, state=RUN, busy=0. An asserted reset drops any held words immediately and mid-transfer; no partial state survives.
- Each channel has a one-entry register. free_N = !outN_valid | outN_ready, so a word can be taken and refilled in the same cycle.
- Target selection uses active_mode (the latched mode, not cfg_mode):
  - MODE_SEL: target = sel.
  - MODE_RR: target = rr_ptr.
  - MODE_AVAIL: target = the free channel. If both are free, target = rr_ptr. If neither is free, target = rr_ptr and in_ready=0.
- in_ready = (state==RUN) & free_target. This is combinational from outN_ready, sel, state and registers. It does not depend on in_valid.
- Accept = in_valid & in_ready. On the next edge:
  - outT_data <= in_data; outT_valid <= 1.
  - In MODE_RR and MODE_AVAIL, rr_ptr <= ~T. In MODE_SEL, rr_ptr holds.
  - Latency from input to output is 1 cycle.
- A held word stays stable (valid and data unchanged) until outN_ready. outN_valid clears on outN_ready unless a new word is loaded in the same cycle.
- Counters: cntN increments on outN_valid & outN_ready and saturates at 2^CNT_W-1. cnt_clr has priority over an increment in the same cycle (result 0).
- FSM, states RUN and DRAIN:
  - RUN -> DRAIN when cfg_mode != active_mode. in_ready is forced to 0 in that same cycle.
  - In DRAIN: busy=1, no acceptance. Held words still drain through the outN handshakes.
  - DRAIN -> RUN on the edge where neither channel will be valid after that edge. On that edge active_mode <= cfg_mode and rr_ptr <= 0.
  - If cfg_mode returns to active_mode during DRAIN, the block still completes the drain. It then re-enters RUN with the same active_mode and rr_ptr reset to 0.
- in_data, sel and cfg_mode are don't-care while in_valid=0. Outputs never contain X after reset.

Decomposition:
- Shared package dispatcher_pkg: mode encodings MODE_SEL=2'd0, MODE_RR=2'd1, MODE_AVAIL=2'd2; state encodings ST_RUN, ST_DRAIN.
- One natural sub-module, dispatch_slot: a one-entry valid/data register with a load/take interface, plus its saturating counter and clear. Instantiate it twice. Target selection and the FSM stay in the top level.

Test Plan:
- MODE_SEL: send words 0x11 (sel=0) and 0x22 (sel=1) back to back with both readies held 1. Expected: out0_data=0x11 one cycle after acceptance, out1_data=0x22 the cycle after that, cnt0=1, cnt1=1, in_ready held 1 throughout.
- MODE_RR with readies at 1: send 4 words 0xA0..0xA3. Expected: 0xA0 and 0xA2 on out0, 0xA1 and 0xA3 on out1, cnt0=cnt1=2. Then stall out1_ready=0 with rr_ptr=1. Expected: in_ready=0 after out1 is filled, and rr_ptr does not advance while stalled.
- MODE_AVAIL: hold out0_ready=0 after out0 is filled and send 3 words. Expected: words go to out1 only, in_ready remains 1, and out0 keeps its word stable.
- Mode change: with out0 holding a word and out0_ready=0, switch cfg_mode 0->1. Expected: busy=1 and in_ready=0. Release out0_ready. Expected: busy falls the cycle after out0 drains, and the next word lands on out0 (rr_ptr reset to 0).
- Boundaries: with CNT_W=4, deliver 17 words on out0. Expected: cnt0 stays at 15. Assert cnt_clr together with a delivery. Expected: cnt0=0.
- Reset mid-operation: assert rst_n=0 while both channels are valid. Expected: outN_valid=0 and counters 0 immediately, asynchronously. After release, the first word is accepted normally.
